// File: rtl/bsg_dmc_trace_bist.sv
// BIST traffic source and read-data checker for the DMC trace-replay port.
// Writes patterned bursts, reads the same addresses back, and checks every returned beat.
module bsg_dmc_trace_bist #(
    parameter int unsigned ui_addr_width_p = 28,
    parameter int unsigned ui_data_width_p = 32,
    parameter int unsigned burst_len_p     = 2,
    parameter int unsigned num_bursts_p    = 16,
    parameter int unsigned addr_stride_p   = 8,
    parameter int unsigned timeout_p       = 1024,
    parameter int unsigned err_width_p     = 16
) (
    input  logic                                             clk_i,
    input  logic                                             reset_n_i,
    input  logic                                             start_i,
    input  logic [ui_data_width_p-1:0]                       seed_i,
    input  logic [ui_addr_width_p-1:0]                       base_addr_i,
    output logic [3+ui_addr_width_p+ui_data_width_p-1:0]     trace_data_o,
    output logic                                             trace_v_o,
    input  logic                                             trace_ready_i,
    input  logic [ui_data_width_p-1:0]                       rd_data_i,
    input  logic                                             rd_v_i,
    output logic                                             rd_yumi_o,
    output logic                                             busy_o,
    output logic                                             done_o,
    output logic                                             pass_o,
    output logic                                             timeout_o,
    output logic [err_width_p-1:0]                           err_count_o
);

    localparam int unsigned addr_w_lp      = ui_addr_width_p;
    localparam int unsigned data_w_lp      = ui_data_width_p;
    localparam int unsigned entry_width_lp = 3 + addr_w_lp + data_w_lp;
    localparam int unsigned total_beats_lp = num_bursts_p * burst_len_p;
    localparam int unsigned burst_w_lp     = $clog2(num_bursts_p + 1);
    localparam int unsigned beat_w_lp      = $clog2(burst_len_p + 1);
    localparam int unsigned rx_w_lp        = $clog2(total_beats_lp + 1);
    localparam int unsigned idle_w_lp      = $clog2(timeout_p + 1);

    localparam logic [2:0] cmd_write_lp = 3'b000;
    localparam logic [2:0] cmd_read_lp  = 3'b001;

    typedef enum logic [2:0] {
        st_idle,
        st_write,
        st_read,
        st_wait,
        st_done
    } state_e;

    state_e                      state_r, state_n;
    logic [data_w_lp-1:0]        seed_r, seed_n;
    logic [addr_w_lp-1:0]        base_r, base_n;
    logic [burst_w_lp-1:0]       burst_r, burst_n;
    logic [beat_w_lp-1:0]        beat_r, beat_n;
    logic [rx_w_lp-1:0]          rx_r, rx_n;
    logic [idle_w_lp-1:0]        idle_r, idle_n;
    logic [err_width_p-1:0]      err_r, err_n;
    logic                        timeout_r, timeout_n;
    logic [entry_width_lp-1:0]   entry_r, entry_n;
    logic                        v_r, v_n;
    logic                        busy_r, busy_n;
    logic                        done_r, done_n;
    logic                        pass_r, pass_n;

    logic                        accept;
    logic                        start_ok;
    logic                        err_inc;
    logic [addr_w_lp-1:0]        addr_n;
    logic [data_w_lp-1:0]        wdata_n;

    // Returned data is never back-pressured.
    assign rd_yumi_o = rd_v_i;

    assign trace_data_o = entry_r;
    assign trace_v_o    = v_r;
    assign busy_o       = busy_r;
    assign done_o       = done_r;
    assign pass_o       = pass_r;
    assign timeout_o    = timeout_r;
    assign err_count_o  = err_r;

    always_comb begin
        state_n   = state_r;
        seed_n    = seed_r;
        base_n    = base_r;
        burst_n   = burst_r;
        beat_n    = beat_r;
        rx_n      = rx_r;
        idle_n    = idle_r;
        timeout_n = timeout_r;
        err_inc   = 1'b0;
        err_n     = err_r;
        v_n       = 1'b0;
        entry_n   = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        pass_n    = 1'b0;
        addr_n    = '0;
        wdata_n   = '0;

        accept   = v_r & trace_ready_i;
        start_ok = start_i & ((state_r == st_idle) | (state_r == st_done));

        // Checker: beats outside the read/wait window are unsolicited errors.
        if (rd_v_i) begin
            if ((state_r == st_read) || (state_r == st_wait)) begin
                err_inc = (rd_data_i != (seed_r + data_w_lp'(rx_r)));
                rx_n    = rx_r + rx_w_lp'(1);
            end else begin
                err_inc = 1'b1;
            end
        end
        if (err_inc && !(&err_r)) begin
            err_n = err_r + err_width_p'(1);
        end

        case (state_r)
            st_idle, st_done: begin
                if (start_ok) begin
                    seed_n    = seed_i;
                    base_n    = base_addr_i;
                    burst_n   = '0;
                    beat_n    = '0;
                    rx_n      = '0;
                    idle_n    = '0;
                    err_n     = '0;
                    timeout_n = 1'b0;
                    state_n   = st_write;
                end
            end
            st_write: begin
                if (accept) begin
                    if (beat_r == beat_w_lp'(burst_len_p - 1)) begin
                        beat_n = '0;
                        if (burst_r == burst_w_lp'(num_bursts_p - 1)) begin
                            burst_n = '0;
                            state_n = st_read;
                        end else begin
                            burst_n = burst_r + burst_w_lp'(1);
                        end
                    end else begin
                        beat_n = beat_r + beat_w_lp'(1);
                    end
                end
            end
            st_read: begin
                if (accept) begin
                    if (burst_r == burst_w_lp'(num_bursts_p - 1)) begin
                        idle_n  = '0;
                        state_n = st_wait;
                    end else begin
                        burst_n = burst_r + burst_w_lp'(1);
                    end
                end
            end
            st_wait: begin
                if (rx_n == rx_w_lp'(total_beats_lp)) begin
                    state_n = st_done;
                end else if (rd_v_i) begin
                    idle_n = '0;
                end else if (idle_r == idle_w_lp'(timeout_p - 1)) begin
                    timeout_n = 1'b1;
                    state_n   = st_done;
                end else begin
                    idle_n = idle_r + idle_w_lp'(1);
                end
            end
            default: state_n = st_idle;
        endcase

        // Registered outputs follow the next state so the entry stays put while stalled.
        addr_n  = base_n + addr_w_lp'(32'(burst_n) * addr_stride_p);
        wdata_n = seed_n + data_w_lp'(32'(burst_n) * burst_len_p + 32'(beat_n));
        if (state_n == st_write) begin
            v_n     = 1'b1;
            entry_n = {cmd_write_lp, addr_n, wdata_n};
        end else if (state_n == st_read) begin
            v_n     = 1'b1;
            entry_n = {cmd_read_lp, addr_n, data_w_lp'(0)};
        end
        busy_n = (state_n == st_write) | (state_n == st_read) | (state_n == st_wait);
        done_n = (state_n == st_done);
        pass_n = done_n & (err_n == '0) & ~timeout_n;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r   <= st_idle;
            seed_r    <= '0;
            base_r    <= '0;
            burst_r   <= '0;
            beat_r    <= '0;
            rx_r      <= '0;
            idle_r    <= '0;
            err_r     <= '0;
            timeout_r <= 1'b0;
            entry_r   <= '0;
            v_r       <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            pass_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            seed_r    <= seed_n;
            base_r    <= base_n;
            burst_r   <= burst_n;
            beat_r    <= beat_n;
            rx_r      <= rx_n;
            idle_r    <= idle_n;
            err_r     <= err_n;
            timeout_r <= timeout_n;
            entry_r   <= entry_n;
            v_r       <= v_n;
            busy_r    <= busy_n;
            done_r    <= done_n;
            pass_r    <= pass_n;
        end
    end

endmodule

// File: tb/tb_bsg_dmc_trace_bist.sv
// Bench for bsg_dmc_trace_bist: scenario table driving a loopback memory model with a scoreboard.
module tb_bsg_dmc_trace_bist;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 32;
    localparam int unsigned EW = 3 + AW + DW;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [DW-1:0] seed;
    logic [AW-1:0] base_addr;
    logic [EW-1:0] trace_data, trace_data_2;
    logic          trace_v, trace_v_2;
    logic          trace_ready;
    logic [DW-1:0] rd_data;
    logic          rd_v;
    logic          rd_yumi, rd_yumi_2;
    logic          busy, busy_2, done, done_2, pass, pass_2, timeout, timeout_2;
    logic [15:0]   err_count;
    logic [1:0]    err_count_2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [DW-1:0] seed;
        logic [AW-1:0] base;
        int            ready_mode;
        logic [7:0]    corrupt;
        logic [7:0]    drop;
        bit            mid_start;
        int            exp_err;
        int            exp_err2;
        bit            exp_pass;
        bit            exp_timeout;
    } scen_t;

    scen_t scen [6];

    bsg_dmc_trace_bist #(
        .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_len_p(2), .num_bursts_p(4),
        .addr_stride_p(8), .timeout_p(16), .err_width_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .seed_i(seed),
        .base_addr_i(base_addr), .trace_data_o(trace_data), .trace_v_o(trace_v),
        .trace_ready_i(trace_ready), .rd_data_i(rd_data), .rd_v_i(rd_v),
        .rd_yumi_o(rd_yumi), .busy_o(busy), .done_o(done), .pass_o(pass),
        .timeout_o(timeout), .err_count_o(err_count)
    );

    // Narrow error counter to exercise saturation; runs in lockstep with dut.
    bsg_dmc_trace_bist #(
        .ui_addr_width_p(AW), .ui_data_width_p(DW), .burst_len_p(2), .num_bursts_p(4),
        .addr_stride_p(8), .timeout_p(16), .err_width_p(2)
    ) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .seed_i(seed),
        .base_addr_i(base_addr), .trace_data_o(trace_data_2), .trace_v_o(trace_v_2),
        .trace_ready_i(trace_ready), .rd_data_i(rd_data), .rd_v_i(rd_v),
        .rd_yumi_o(rd_yumi_2), .busy_o(busy_2), .done_o(done_2), .pass_o(pass_2),
        .timeout_o(timeout_2), .err_count_o(err_count_2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_scen(input int idx, input bit abort_rd);
        scen_t         s;
        logic [EW-1:0] exp_q[$];
        logic [DW-1:0] pend_q[$];
        int            pend_due[$];
        logic [EW-1:0] e;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            done_cyc;
        int            last_beat;
        int            rd_idx;
        int            r;
        s = scen[idx];
        done_cyc  = -1;
        last_beat = -1;
        rd_idx    = 0;

        // Scoreboard: every entry the DUT must emit, in order.
        for (int i = 0; i < 8; i++) begin
            a = s.base + AW'((i / 2) * 8);
            d = s.seed + DW'(i);
            e = {3'b000, a, d};
            exp_q.push_back(e);
        end
        for (int b = 0; b < 4; b++) begin
            a = s.base + AW'(b * 8);
            e = {3'b001, a, 32'h0};
            exp_q.push_back(e);
        end

        @(posedge clk); #1;
        start = 1'b1; seed = s.seed; base_addr = s.base;
        @(posedge clk); #1;
        start = 1'b0; seed = $urandom; base_addr = AW'($urandom);
        trace_ready = 1'b1; rd_v = 1'b0;
        @(negedge clk);
        check($sformatf("s%0d_start_flags", idx), 64'({busy, done, pass, timeout, trace_v}), 64'b10001);
        check($sformatf("s%0d_start_err", idx), 64'(err_count), 64'd0);

        for (int cyc = 0; cyc < 400; cyc++) begin
            if (rd_v) begin
                check($sformatf("s%0d_yumi", idx), 64'(rd_yumi), 64'd1);
                if (pend_q.size() > 0) begin
                    void'(pend_q.pop_front());
                    void'(pend_due.pop_front());
                end
                last_beat = cyc;
            end
            if (trace_v && trace_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL s%0d_extra_entry: got 0x%0h expected no entry", idx, trace_data);
                end else begin
                    check($sformatf("s%0d_entry", idx), 64'(trace_data), 64'(exp_q.pop_front()));
                end
                if (trace_data[EW-1 -: 3] == 3'b001) begin
                    for (int k = 0; k < 2; k++) begin
                        r = rd_idx * 2 + k;
                        if (!s.drop[r]) begin
                            pend_q.push_back(s.corrupt[r] ? 32'hFF : s.seed + DW'(r));
                            pend_due.push_back(cyc + 4);
                        end
                    end
                    rd_idx++;
                    if (abort_rd) begin
                        #1 reset_n = 1'b0; rd_v = 1'b0;
                        #1;
                        check("reset_async_data", 64'(trace_data), 64'd0);
                        check("reset_async_flags", 64'({trace_v, busy, done, pass, timeout, err_count}), 64'd0);
                        check("reset_async_dut2", 64'({trace_v_2, busy_2, err_count_2}), 64'd0);
                        repeat (2) @(posedge clk);
                        @(negedge clk);
                        check("reset_hold_quiet", 64'({trace_v, busy}), 64'd0);
                        reset_n = 1'b1;
                        return;
                    end
                end
            end else if (trace_v && exp_q.size() > 0) begin
                check($sformatf("s%0d_stall_entry", idx), 64'(trace_data), 64'(exp_q[0]));
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            trace_ready = (s.ready_mode == 0) || (((cyc + 1) % 3) == 0);
            start = s.mid_start && (cyc == 2);
            if (start) seed = 32'hDEAD_BEEF;
            if (pend_q.size() > 0 && pend_due[0] <= cyc + 1) begin
                rd_v = 1'b1;
                rd_data = pend_q[0];
            end else begin
                rd_v = 1'b0;
                rd_data = $urandom;
            end
            @(negedge clk);
        end
        start = 1'b0;
        rd_v  = 1'b0;

        check($sformatf("s%0d_done_seen", idx), 64'(done_cyc >= 0), 64'd1);
        check($sformatf("s%0d_all_entries", idx), 64'(exp_q.size()), 64'd0);
        check($sformatf("s%0d_err_count", idx), 64'(err_count), 64'(s.exp_err));
        check($sformatf("s%0d_err_count_sat", idx), 64'(err_count_2), 64'(s.exp_err2));
        check($sformatf("s%0d_pass", idx), 64'(pass), 64'(s.exp_pass));
        check($sformatf("s%0d_timeout", idx), 64'(timeout), 64'(s.exp_timeout));
        check($sformatf("s%0d_idle_after", idx), 64'({busy, trace_v}), 64'd0);
        if (s.exp_timeout) begin
            check($sformatf("s%0d_timeout_latency", idx), 64'(done_cyc - last_beat), 64'd17);
        end
    endtask

    initial begin
        scen[0] = '{32'h10, 28'h100, 0, 8'h00, 8'h00, 1'b0, 0, 0, 1'b1, 1'b0};
        scen[1] = '{32'h10, 28'h100, 0, 8'h20, 8'h00, 1'b0, 1, 1, 1'b0, 1'b0};
        scen[2] = '{32'h10, 28'h100, 1, 8'h00, 8'h00, 1'b0, 0, 0, 1'b1, 1'b0};
        scen[3] = '{32'h10, 28'h100, 0, 8'h00, 8'hC0, 1'b0, 0, 0, 1'b0, 1'b1};
        scen[4] = '{32'h10, 28'h100, 0, 8'hFF, 8'h00, 1'b0, 8, 3, 1'b0, 1'b0};
        scen[5] = '{32'hFFFF_FFFE, 28'hFFF_FFF8, 0, 8'h00, 8'h00, 1'b1, 0, 0, 1'b1, 1'b0};

        clk = 1'b0; reset_n = 1'b0; start = 1'b0; seed = '0; base_addr = '0;
        trace_ready = 1'b0; rd_data = '0; rd_v = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data", 64'(trace_data), 64'd0);
        check("reset_flags", 64'({trace_v, busy, done, pass, timeout, err_count}), 64'd0);
        reset_n = 1'b1;

        // Unsolicited beat while idle.
        @(posedge clk); #1;
        rd_v = 1'b1; rd_data = 32'h10;
        @(negedge clk);
        check("idle_yumi", 64'(rd_yumi), 64'd1);
        @(posedge clk); #1;
        rd_v = 1'b0;
        @(negedge clk);
        check("idle_beat_err", 64'(err_count), 64'd1);
        check("idle_beat_err2", 64'(err_count_2), 64'd1);
        check("idle_beat_flags", 64'({busy, done, trace_v}), 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_scen(i, 1'b0);
        end
        run_scen(0, 1'b1);
        run_scen(0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_dmc_trace_bist.md
Name: bsg_dmc_trace_bist

Overview:
- Built-in self-test traffic source and checker for the DMC trace-replay port, in the UI clock domain.
- Drives trace entries (v/ready) into the trace-replay input: a write pass of patterned bursts, then a read pass over the same addresses.
- Consumes returned read data (v/yumi) and compares each beat against the regenerated pattern.
- Reports done, pass, error count and timeout status to the test host / tag logic.

Parameters:
- ui_addr_width_p, 28, UI address width.
- ui_data_width_p, 32, UI data beat width.
- burst_len_p, 2, UI beats per burst.
- num_bursts_p, 16, bursts per test pass; must be >= 1.
- addr_stride_p, 8, address increment per burst.
- timeout_p, 1024, maximum idle cycles allowed while waiting for read data.
- err_width_p, 16, error counter width.
- Derived: entry_width_lp = 3 + ui_addr_width_p + ui_data_width_p.

Ports:
- clk_i  in  1  UI clock.
- reset_n_i  in  1  Reset, asynchronous, active-low.
- start_i  in  1  Start pulse; sampled only in IDLE or DONE.
- seed_i  in  ui_data_width_p  Pattern seed; captured on an accepted start.
- base_addr_i  in  ui_addr_width_p  First burst address; captured on an accepted start.
- trace_data_o  out  entry_width_lp  Entry packed MSB-first as {cmd[2:0], addr, wdata}; cmd 3'b000 = write, 3'b001 = read.
- trace_v_o  out  1  Entry valid.
- trace_ready_i  in  1  Replay can accept an entry.
- rd_data_i  in  ui_data_width_p  Returned read beat.
- rd_v_i  in  1  Read beat valid.
- rd_yumi_o  out  1  Read beat consumed.
- busy_o  out  1  Test running.
- done_o  out  1  Test finished (sticky until next start).
- pass_o  out  1  Valid when done_o: no errors and no timeout.
- timeout_o  out  1  Test ended by timeout.
- err_count_o  out  err_width_p  Mismatch count, saturating.

Behaviour:
- Reset (asynchronous): state IDLE; all counters zero; all outputs 0.
- States: IDLE, WRITE, READ, WAIT, DONE.
- IDLE/DONE + start_i:
  - Capture seed and base address.
  - Clear counters, err_count_o and timeout_o; drop done_o.
  - Go to WRITE; trace_v_o rises the next cycle.
- WRITE:
  - Emits num_bursts_p*burst_len_p entries, cmd = write.
  - addr = base + b*addr_stride_p; data = seed + (b*burst_len_p + k), both mod 2^width (b = burst index, k = beat index).
  - Entry held stable while trace_v_o & ~trace_ready_i.
  - Counters advance only on v&ready.
  - Last accepted write goes to READ.
- READ:
  - Emits num_bursts_p entries, cmd = write→read (3'b001), addr as above, data field 0.
  - Last accepted read goes to WAIT.
- Checker runs in READ and WAIT:
  - rd_yumi_o = rd_v_i in every state; the block never back-pressures returned data.
  - Each beat is compared to expected(rx_count); rx_count increments per beat.
  - A mismatch increments err_count_o, saturating at all-ones.
  - A beat arriving in IDLE, WRITE or DONE is consumed and counted as an error.
- WAIT exits:
  - rx_count reaches num_bursts_p*burst_len_p (including on the beat that reaches it): go to DONE.
  - Idle counter reaches timeout_p with no rd_v_i: go to DONE, set timeout_o.
  - The idle counter resets on each beat and runs only in WAIT.
- DONE:
  - done_o = 1; pass_o = (err_count_o == 0) & ~timeout_o; busy_o = 0.
- busy_o = 1 in WRITE, READ and WAIT.
- start_i outside IDLE/DONE is ignored.
- Reset asserted mid-test aborts immediately to IDLE with no further entries.
- All arithmetic wraps modulo field width; no address overflow check.

Test Plan:
- Loopback model, burst_len 2, 4 bursts, base 0x100, stride 8, seed 0x10:
  - 8 writes seen: addr 0x100,0x100,0x108,...,0x118; data 0x10..0x17.
  - 4 reads then follow; echoed data gives done_o=1, pass_o=1, err_count_o=0.
- Same run, model corrupts beat 5 (returns 0xFF):
  - err_count_o=1, pass_o=0, timeout_o=0.
- trace_ready_i toggled 1 cycle on / 2 off during writes:
  - Entries unchanged while stalled; exactly 8 writes and 4 reads, no duplicates.
- Model returns only 6 of 8 beats, timeout_p=16:
  - DONE 16 cycles after the last beat; timeout_o=1, pass_o=0.
- Unsolicited beats and restart:
  - rd_v_i pulse in IDLE gives err_count_o=1.
  - start_i again clears it to 0.
  - start_i pulsed mid-WRITE is ignored.
- Reset and saturation:
  - reset_n_i low mid-READ: all outputs 0 asynchronously; restart passes.
  - err_width_p=2 with all beats corrupted: err_count_o saturates at 3.
